// File: rtl/mp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mp_fifo
// Brief    : Multi-lane push/pop FIFO on a modulo-INT_DEPTH circular buffer,
//            zero-latency read lanes; optional cnt port via MP_FIFO_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef Disable
`define Disable 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif

module mp_fifo #(
    parameter int DATA    = 64,
    parameter int DEPTH   = 8,
    parameter bit BUF_EXT = `Disable,
    parameter int PUSH    = 1,
    parameter int POP     = 1,
    localparam int INT_DEPTH = BUF_EXT ? DEPTH + PUSH : DEPTH,
    localparam int CW        = $clog2(INT_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      flush_,
    input  logic [PUSH-1:0]           push_,
    input  logic [PUSH-1:0][DATA-1:0] wd,
    input  logic [POP-1:0]            pop_,
    output logic [POP-1:0][DATA-1:0]  rd,
    output logic [POP-1:0]            v,
    output logic                      busy
`ifdef MP_FIFO_CNT_EN
    ,
    output logic [CW-1:0]             cnt
`endif
);

    localparam int PW = (INT_DEPTH > 1) ? $clog2(INT_DEPTH) : 1;

    logic [DATA-1:0] mem_q [INT_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   occ_q, occ_d;

    int wnum, rnum, eff_r, eff_w, room;

    // Pointer arithmetic wraps at INT_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int off);
        return PW'((int'(base) + off) % INT_DEPTH);
    endfunction

    always_comb begin
        wnum = 0;
        rnum = 0;
        for (int i = 0; i < PUSH; i++)
            if (!push_[i]) wnum = wnum + 1;
        for (int i = 0; i < POP; i++)
            if (!pop_[i]) rnum = rnum + 1;
        eff_r  = (rnum < int'(occ_q)) ? rnum : int'(occ_q);
        // Slots freed by this cycle's pops are reusable by this cycle's pushes.
        room   = INT_DEPTH - int'(occ_q) + eff_r;
        eff_w  = (wnum < room) ? wnum : room;
        occ_d  = CW'(int'(occ_q) + eff_w - eff_r);
        head_d = slot(head_q, eff_r);
        tail_d = slot(tail_q, eff_w);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            for (int k = 0; k < INT_DEPTH; k++)
                mem_q[k] <= '0;
        end else if (!flush_) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < PUSH; i++)
                if (i < eff_w) mem_q[slot(tail_q, i)] <= wd[i];
        end
    end

    generate
        for (genvar j = 0; j < POP; j++) begin : g_rd
            assign rd[j] = mem_q[slot(head_q, j)];
            assign v[j]  = (j < int'(occ_q));
        end
    endgenerate

    assign busy = (INT_DEPTH - int'(occ_q)) < PUSH;

`ifdef MP_FIFO_CNT_EN
    assign cnt = occ_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_fifo
// Brief    : Self-checking bench; two mp_fifo instances (depth 4, and depth 4
//            with buffer extension) driven in lockstep against queue models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_fifo;

    logic            clk = 1'b0;
    logic            reset_;
    logic            flush_;
    logic [1:0]      push_;
    logic [1:0][7:0] wd;
    logic [1:0]      pop_;

    logic [1:0][7:0] rd_a, rd_b;
    logic [1:0]      v_a, v_b;
    logic            busy_a, busy_b;
`ifdef MP_FIFO_CNT_EN
    logic [2:0]      cnt_a, cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    mp_fifo #(.DATA(8), .DEPTH(4), .BUF_EXT(1'b0), .PUSH(2), .POP(2)) dut_a (
        .clk(clk), .reset_(reset_), .flush_(flush_), .push_(push_), .wd(wd),
        .pop_(pop_), .rd(rd_a), .v(v_a), .busy(busy_a)
`ifdef MP_FIFO_CNT_EN
        , .cnt(cnt_a)
`endif
    );

    mp_fifo #(.DATA(8), .DEPTH(4), .BUF_EXT(1'b1), .PUSH(2), .POP(2)) dut_b (
        .clk(clk), .reset_(reset_), .flush_(flush_), .push_(push_), .wd(wd),
        .pop_(pop_), .rd(rd_b), .v(v_b), .busy(busy_b)
`ifdef MP_FIFO_CNT_EN
        , .cnt(cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] ev;
        for (int j = 0; j < 2; j++) ev[j] = (j < qa.size());
        chk({tag, ".A.v"}, 64'(v_a), 64'(ev));
        for (int j = 0; j < 2 && j < qa.size(); j++)
            chk($sformatf("%s.A.rd%0d", tag, j), 64'(rd_a[j]), 64'(qa[j]));
        chk({tag, ".A.busy"}, 64'(busy_a), 64'((4 - qa.size()) < 2));
        for (int j = 0; j < 2; j++) ev[j] = (j < qb.size());
        chk({tag, ".B.v"}, 64'(v_b), 64'(ev));
        for (int j = 0; j < 2 && j < qb.size(); j++)
            chk($sformatf("%s.B.rd%0d", tag, j), 64'(rd_b[j]), 64'(qb[j]));
        chk({tag, ".B.busy"}, 64'(busy_b), 64'((6 - qb.size()) < 2));
`ifdef MP_FIFO_CNT_EN
        chk({tag, ".A.cnt"}, 64'(cnt_a), 64'(qa.size()));
        chk({tag, ".B.cnt"}, 64'(cnt_b), 64'(qb.size()));
`endif
    endtask

    // Queue model: pops see only pre-cycle contents, pushes fill whatever room remains.
    task automatic model_update(input logic [1:0] pn, input logic [15:0] w,
                                input logic [1:0] rn, input logic fn);
        int wn, rcnt, n;
        logic [1:0][7:0] wl;
        wl = w;
        if (!fn) begin
            qa.delete();
            qb.delete();
            return;
        end
        wn   = (pn[0] ? 0 : 1) + (pn[1] ? 0 : 1);
        rcnt = (rn[0] ? 0 : 1) + (rn[1] ? 0 : 1);
        n = (rcnt < qa.size()) ? rcnt : qa.size();
        repeat (n) void'(qa.pop_front());
        n = (wn < 4 - qa.size()) ? wn : 4 - qa.size();
        for (int i = 0; i < n; i++) qa.push_back(wl[i]);
        n = (rcnt < qb.size()) ? rcnt : qb.size();
        repeat (n) void'(qb.pop_front());
        n = (wn < 6 - qb.size()) ? wn : 6 - qb.size();
        for (int i = 0; i < n; i++) qb.push_back(wl[i]);
    endtask

    task automatic step(input logic [1:0] pn, input logic [15:0] w,
                        input logic [1:0] rn, input logic fn, input string tag);
        push_  = pn;
        wd     = w;
        pop_   = rn;
        flush_ = fn;
        @(posedge clk);
        model_update(pn, w, rn, fn);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_ = 1'b0;
        flush_ = 1'b1;
        push_  = 2'b11;
        pop_   = 2'b11;
        wd     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.A.rd", 64'(rd_a), 64'h0);
        chk("rst.B.rd", 64'(rd_b), 64'h0);
        check_all("rst");
        #2 reset_ = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.A.rd", 64'(rd_a), 64'h0);
        check_all("post_rst");

        // Two-lane push: lane 0 is the older entry.
        step(2'b00, {8'h11, 8'h22}, 2'b11, 1'b1, "dual_push");
        chk("dual_push.A.rd0_lit", 64'(rd_a[0]), 64'h22);
        chk("dual_push.A.rd1_lit", 64'(rd_a[1]), 64'h11);

        // Fill to 3 (busy), then a dual push only has room for lane 0.
        step(2'b10, {8'h99, 8'h33}, 2'b11, 1'b1, "fill3");
        chk("fill3.A.busy_lit", 64'(busy_a), 64'h1);
        step(2'b00, {8'h55, 8'h44}, 2'b11, 1'b1, "overflow");

        // Full with simultaneous dual push and dual pop, wrapping the tail.
        step(2'b00, {8'h77, 8'h66}, 2'b00, 1'b1, "full_pushpop");
        chk("full_pushpop.A.rd0_lit", 64'(rd_a[0]), 64'h33);
        step(2'b11, 16'h0, 2'b00, 1'b1, "drain1");
        step(2'b11, 16'h0, 2'b00, 1'b1, "drain2");
        step(2'b11, 16'h0, 2'b00, 1'b1, "drain3");

        // Single entry with a dual pop retires only one.
        step(2'b10, {8'h00, 8'hA1}, 2'b11, 1'b1, "one");
        step(2'b11, 16'h0, 2'b00, 1'b1, "pop_over");
        chk("pop_over.A.v_lit", 64'(v_a), 64'h0);
        step(2'b00, {8'hB2, 8'hB1}, 2'b11, 1'b1, "after_pop_over");

        // Flush overrides a same-cycle push.
        step(2'b10, {8'h00, 8'hC1}, 2'b11, 1'b1, "pre_flush");
        step(2'b00, {8'hD2, 8'hD1}, 2'b00, 1'b0, "flush");
        chk("flush.A.v_lit", 64'(v_a), 64'h0);

        // Asynchronous reset in the middle of a burst.
        step(2'b00, {8'hE2, 8'hE1}, 2'b11, 1'b1, "burst");
        push_ = 2'b00;
        pop_  = 2'b00;
        wd    = {8'hF2, 8'hF1};
        #3 reset_ = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        chk("async_rst.A.v", 64'(v_a), 64'h0);
        chk("async_rst.A.rd", 64'(rd_a), 64'h0);
        chk("async_rst.B.rd", 64'(rd_b), 64'h0);
        @(posedge clk);
        #1;
        check_all("async_rst_hold");
        chk("async_rst_hold.A.rd", 64'(rd_a), 64'h0);
        #2 reset_ = 1'b1;
        push_ = 2'b11;
        pop_  = 2'b11;
        @(posedge clk);
        #1;
        check_all("rst_release");

        // Alternating dual pushes and single pops walk the extended buffer past its wrap.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                step(2'b00, 16'($urandom), 2'b11, 1'b1, $sformatf("alt%0d", i));
            else
                step(2'b11, 16'h0, 2'b10, 1'b1, $sformatf("alt%0d", i));
        end

        for (int i = 0; i < 300; i++)
            step(2'($urandom), 16'($urandom), 2'($urandom), ($urandom_range(0, 15) != 0),
                 $sformatf("rnd%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
